// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// FSM state encoding, supported prescale ratios and default widths.
package uart_rx_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PRESCALE_W = 6;

   localparam logic [DEF_PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
   localparam logic [DEF_PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
   localparam logic [DEF_PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-tap majority sampler.
// Ports: clk, rst_n, run (clears counter when low), rx, prescale;
//        edge_cnt, bit_end, bit_take/bit_nxt (cycle before decision),
//        bit_val/bit_rdy (registered vote, decision cycle).
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  rx,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  bit_end,
   output logic                  bit_take,
   output logic                  bit_nxt,
   output logic                  bit_val,
   output logic                  bit_rdy
);

   logic [PRESCALE_W-1:0] half;
   logic                  tap0;
   logic                  tap1;
   logic                  s0;
   logic                  s1;

   assign half     = prescale >> 1;
   assign tap0     = (edge_cnt == half - PRESCALE_W'(1));
   assign tap1     = (edge_cnt == half);
   assign bit_take = (edge_cnt == half + PRESCALE_W'(1));
   assign bit_end  = (edge_cnt == prescale - PRESCALE_W'(1));

   // third sample is the live line, so the vote is ready one cycle
   // early and the consumer can register its result for the decision
   assign bit_nxt = (s0 & s1) | (s0 & rx) | (s1 & rx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         s0       <= 1'b0;
         s1       <= 1'b0;
         bit_val  <= 1'b0;
         bit_rdy  <= 1'b0;
      end else if (!run) begin
         edge_cnt <= '0;
         bit_rdy  <= 1'b0;
      end else begin
         edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
         if (tap0) s0 <= rx;
         if (tap1) s1 <= rx;
         bit_rdy <= bit_take;
         if (bit_take) bit_val <= bit_nxt;
      end
   end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, LSB-first deserialize,
// optional parity capture and stop check feeding a parity checker.
// Ports: CLK, Reset (async low), RX_IN, Prescale, PAR_EN, Parity_error;
//        P_Data, Parity_bit, Parity_check_EN, Data_valid, Stop_error.
module uart_rx_frame_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  Parity_error,
   output logic [DATA_WIDTH-1:0] P_Data,
   output logic                  Parity_bit,
   output logic                  Parity_check_EN,
   output logic                  Data_valid,
   output logic                  Stop_error
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] pscale;
   logic                  par_en_q;
   logic                  par_err_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  start_det;
   logic                  run;
   logic                  err_take;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic                  bit_end;
   logic                  bit_take;
   logic                  bit_nxt;
   logic                  bit_val;
   logic                  bit_rdy;
   logic                  shift;
   logic                  par_take;
   logic                  dv_d;
   logic                  se_d;

   assign start_det = (state == IDLE) && !RX_IN;
   assign pscale    = start_det ? Prescale : prescale_q;
   // counter runs while the next cycle is inside a frame, so it is
   // already 0 when a back-to-back start is seen right after STOP
   assign run       = (state_nxt != IDLE);
   // checker answer arrives one cycle after the strobe
   assign err_take  = (state == PARITY) &&
                      (edge_cnt == (prescale_q >> 1) + PRESCALE_W'(3));

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk      (CLK),
      .rst_n    (Reset),
      .run      (run),
      .rx       (RX_IN),
      .prescale (pscale),
      .edge_cnt (edge_cnt),
      .bit_end  (bit_end),
      .bit_take (bit_take),
      .bit_nxt  (bit_nxt),
      .bit_val  (bit_val),
      .bit_rdy  (bit_rdy)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (!RX_IN) state_nxt = START;
         START: begin
            if (bit_rdy && bit_val) state_nxt = IDLE;
            else if (bit_end)       state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == LAST)
               state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: if (bit_end) state_nxt = STOP;
         STOP:   if (bit_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shift    = 1'b0;
      par_take = 1'b0;
      dv_d     = 1'b0;
      se_d     = 1'b0;
      unique case (1'b1)
         (state == DATA):   shift    = bit_take;
         (state == PARITY): par_take = bit_take;
         (state == STOP): begin
            dv_d = bit_take && bit_nxt && !(par_en_q && par_err_q);
            se_d = bit_take && !bit_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         prescale_q      <= '0;
         par_en_q        <= 1'b0;
         par_err_q       <= 1'b0;
         bit_cnt         <= '0;
         P_Data          <= '0;
         Parity_bit      <= 1'b0;
         Parity_check_EN <= 1'b0;
         Data_valid      <= 1'b0;
         Stop_error      <= 1'b0;
      end else begin
         if (start_det) begin
            prescale_q <= Prescale;
            par_en_q   <= PAR_EN;
            par_err_q  <= 1'b0;
         end else if (err_take) begin
            par_err_q  <= Parity_error;
         end
         if (state == DATA && bit_end)
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CNT_W'(1);
         if (shift)
            P_Data <= {bit_nxt, P_Data[DATA_WIDTH-1:1]};
         if (par_take)
            Parity_bit <= bit_nxt;
         Parity_check_EN <= par_take;
         Data_valid      <= dv_d;
         Stop_error      <= se_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frames, parity, glitch,
// stop error, back-to-back frames and mid-frame reset.
module tb_uart_rx_frame_ctrl;
   import uart_rx_pkg::*;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       Parity_error;
   logic [7:0] P_Data;
   logic       Parity_bit;
   logic       Parity_check_EN;
   logic       Data_valid;
   logic       Stop_error;

   int n_vec = 0;
   int n_err = 0;

   logic line_mem [0:511];
   logic perr_val;

   int         dv_n, se_n, pce_n, both_n, both_total;
   int         dv_at [4];
   logic [7:0] dv_data [4];
   int         se_at, pce_at, idle_at;
   bit         rst_hit;
   logic [7:0] rs_pdata;
   logic       rs_pb, rs_pce, rs_dv, rs_se;
   state_t     rs_state;

   always #5 CLK = ~CLK;

   uart_rx_frame_ctrl dut (
      .CLK             (CLK),
      .Reset           (Reset),
      .RX_IN           (RX_IN),
      .Prescale        (Prescale),
      .PAR_EN          (PAR_EN),
      .Parity_error    (Parity_error),
      .P_Data          (P_Data),
      .Parity_bit      (Parity_bit),
      .Parity_check_EN (Parity_check_EN),
      .Data_valid      (Data_valid),
      .Stop_error      (Stop_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic line_idle();
      for (int i = 0; i < 512; i++) line_mem[i] = 1'b1;
   endtask

   task automatic put_frame(input int at, input int p,
                            input logic [7:0] d, input bit par,
                            input logic pb, input logic stop);
      logic [10:0] f;
      int          nb;
      f  = {stop, pb, d, 1'b0};
      nb = par ? 11 : 10;
      if (!par) f[9] = stop;
      for (int k = 0; k < nb; k++)
         for (int j = 0; j < p; j++)
            if (at + k * p + j < 512) line_mem[at + k * p + j] = f[k];
   endtask

   // iteration c observes the outputs of cycle c, then drives cycle c
   task automatic run(input int ncyc, input int rst_at);
      logic prev_pce;
      prev_pce = 1'b0;
      dv_n = 0; se_n = 0; pce_n = 0; both_n = 0;
      se_at = -1; pce_at = -1; idle_at = -1; rst_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dv_at[i] = -1;
         dv_data[i] = 8'h00;
      end
      for (int c = 0; c < ncyc; c++) begin
         if (c == rst_at) begin
            Reset = 1'b0;
            #1;
            rst_hit  = 1'b1;
            rs_pdata = P_Data;
            rs_pb    = Parity_bit;
            rs_pce   = Parity_check_EN;
            rs_dv    = Data_valid;
            rs_se    = Stop_error;
            rs_state = dut.state;
            break;
         end
         if (Data_valid) begin
            if (dv_n < 4) begin
               dv_at[dv_n]   = c;
               dv_data[dv_n] = P_Data;
            end
            dv_n++;
         end
         if (Stop_error) begin
            if (se_at < 0) se_at = c;
            se_n++;
         end
         if (Parity_check_EN) begin
            if (pce_at < 0) pce_at = c;
            pce_n++;
         end
         if (Data_valid && Stop_error) both_n++;
         if (c > 0 && idle_at < 0 && dut.state == IDLE) idle_at = c;
         Parity_error = prev_pce ? perr_val : 1'b0;
         prev_pce     = Parity_check_EN;
         RX_IN        = (c < 512) ? line_mem[c] : 1'b1;
         @(posedge CLK);
         #1;
      end
      RX_IN        = 1'b1;
      Parity_error = 1'b0;
      both_total  += both_n;
   endtask

   initial begin
      both_total   = 0;
      Reset        = 1'b0;
      RX_IN        = 1'b1;
      Prescale     = 6'd8;
      PAR_EN       = 1'b0;
      Parity_error = 1'b0;
      perr_val     = 1'b0;
      line_idle();
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_pdata", 32'(P_Data), 32'h0);
      chk("rst_pbit", 32'(Parity_bit), 32'h0);
      chk("rst_pce", 32'(Parity_check_EN), 32'h0);
      chk("rst_dv", 32'(Data_valid), 32'h0);
      chk("rst_se", 32'(Stop_error), 32'h0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      Reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // P=8, no parity, 0xA5, one disagreeing sample in two bits
      line_idle();
      put_frame(0, 8, 8'hA5, 1'b0, 1'b0, 1'b1);
      line_mem[11] = 1'b0;
      line_mem[20] = 1'b1;
      Prescale = 6'd8; PAR_EN = 1'b0; perr_val = 1'b0;
      run(90, -1);
      chk("t1_dv_n", dv_n, 1);
      chk("t1_dv_at", dv_at[0], 78);
      chk("t1_pdata", 32'(dv_data[0]), 32'hA5);
      chk("t1_se_n", se_n, 0);
      chk("t1_pce_n", pce_n, 0);
      chk("t1_idle", idle_at, 79);

      // P=8, parity present, checker reports an error
      line_idle();
      put_frame(0, 8, 8'h0F, 1'b1, 1'b1, 1'b1);
      PAR_EN = 1'b1; perr_val = 1'b1;
      run(95, -1);
      chk("t3_pce_n", pce_n, 1);
      chk("t3_pce_at", pce_at, 78);
      chk("t3_dv_n", dv_n, 0);
      chk("t3_se_n", se_n, 0);
      chk("t3_idle", idle_at, 87);
      chk("t3_pbit", 32'(Parity_bit), 32'h1);
      chk("t3_pdata", 32'(P_Data), 32'h0F);

      // P=16, parity good; error latch must have been cleared
      line_idle();
      put_frame(0, 16, 8'h3C, 1'b1, 1'b0, 1'b1);
      Prescale = 6'd16; PAR_EN = 1'b1; perr_val = 1'b0;
      run(180, -1);
      chk("t2_pce_at", pce_at, 154);
      chk("t2_pce_n", pce_n, 1);
      chk("t2_dv_n", dv_n, 1);
      chk("t2_dv_at", dv_at[0], 170);
      chk("t2_pdata", 32'(dv_data[0]), 32'h3C);
      chk("t2_pbit", 32'(Parity_bit), 32'h0);
      chk("t2_idle", idle_at, 171);

      // P=8 glitch: three low cycles then high
      line_idle();
      for (int i = 0; i < 3; i++) line_mem[i] = 1'b0;
      Prescale = 6'd8; PAR_EN = 1'b0;
      run(20, -1);
      chk("t4_dv_n", dv_n, 0);
      chk("t4_se_n", se_n, 0);
      chk("t4_pce_n", pce_n, 0);
      chk("t4_idle", idle_at, 7);
      chk("t4_pdata", 32'(P_Data), 32'h3C);

      // P=32, stop bit low
      line_idle();
      put_frame(0, 32, 8'h5A, 1'b0, 1'b0, 1'b0);
      Prescale = 6'd32; PAR_EN = 1'b0;
      run(340, -1);
      chk("t5_se_n", se_n, 1);
      chk("t5_se_at", se_at, 306);
      chk("t5_dv_n", dv_n, 0);
      chk("t5_pdata", 32'(P_Data), 32'h5A);
      chk("t5_idle", idle_at, 307);

      // back-to-back 0x01, 0xFF, then reset inside a third frame
      line_idle();
      put_frame(0, 8, 8'h01, 1'b0, 1'b0, 1'b1);
      put_frame(79, 8, 8'hFF, 1'b0, 1'b0, 1'b1);
      put_frame(158, 8, 8'h55, 1'b0, 1'b0, 1'b1);
      Prescale = 6'd8; PAR_EN = 1'b0;
      run(400, 198);
      chk("t6_rst_hit", 32'(rst_hit), 32'h1);
      chk("t6_dv_n", dv_n, 2);
      chk("t6_dv0_at", dv_at[0], 78);
      chk("t6_dv1_at", dv_at[1], 157);
      chk("t6_dv0_data", 32'(dv_data[0]), 32'h01);
      chk("t6_dv1_data", 32'(dv_data[1]), 32'hFF);
      chk("t6_se_n", se_n, 0);
      chk("t6_rst_pdata", 32'(rs_pdata), 32'h0);
      chk("t6_rst_pbit", 32'(rs_pb), 32'h0);
      chk("t6_rst_pce", 32'(rs_pce), 32'h0);
      chk("t6_rst_dv", 32'(rs_dv), 32'h0);
      chk("t6_rst_se", 32'(rs_se), 32'h0);
      chk("t6_rst_state", 32'(rs_state), 32'(IDLE));
      RX_IN = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      Reset = 1'b1;
      line_idle();
      run(100, -1);
      chk("t6_post_dv_n", dv_n, 0);
      chk("t6_post_se_n", se_n, 0);
      chk("t6_post_idle", idle_at, 1);
      chk("dv_se_overlap", both_total, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
